// File: rtl/sysid_chk_pkg.sv
// sysid_boot_checker shared types
// FSM states, fail codes and slave word addresses
package sysid_chk_pkg;

  typedef enum logic [2:0] {
    WAIT,
    RD_ID,
    RD_TS,
    CHECK,
    DONE
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ID      = 2'd1;
  localparam logic [1:0] FC_TS      = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int TMR_W = 16;

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read bus between the checker and the system-ID slave
// master drives address/read, slave drives waitrequest/readdata
interface sysid_boot_checker_if;

  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/sysid_chk_timer.sv
// Loadable down-counter for start delay and read stall timeout
// expired is high whenever the count sits at zero
module sysid_chk_timer #(
  parameter int            W       = 16,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt;

  // clear beats load beats decrement; saturates at zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RST_VAL;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads ID and timestamp, retries, reports
// Optional irq/irq_ack ports under macro SYSID_CHK_IRQ_EN
module sysid_boot_checker
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXP_ID         = 32'd0,
  parameter logic [31:0] EXP_TIMESTAMP  = 32'd1380386782,
  parameter int          START_DELAY    = 16,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRY      = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  sysid_boot_checker_if.master avm,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [1:0]   fail_code,
  output logic [31:0]  id_value,
  output logic [31:0]  ts_value,
  output logic [1:0]   retry_cnt
`ifdef SYSID_CHK_IRQ_EN
  ,
  output logic         irq,
  input  logic         irq_ack
`endif
);

  localparam logic [TMR_W-1:0] DLY_VAL = TMR_W'(START_DELAY);
  localparam logic [TMR_W-1:0] TMO_VAL = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic       tmo;
  logic [1:0] code;
  logic       tmr_clr;
  logic       tmr_load;
  logic       tmr_dec;
  logic       tmr_exp;

  sysid_chk_timer #(
    .W       (TMR_W),
    .RST_VAL (DLY_VAL)
  ) u_tmr (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (tmr_clr),
    .load     (tmr_load),
    .load_val (TMO_VAL),
    .dec      (tmr_dec),
    .expired  (tmr_exp)
  );

  // first error wins: timeout, then ID, then timestamp
  always_comb begin
    code = FC_NONE;
    priority case (1'b1)
      tmo:                       code = FC_TIMEOUT;
      id_value != EXP_ID:        code = FC_ID;
      ts_value != EXP_TIMESTAMP: code = FC_TS;
      default:                   code = FC_NONE;
    endcase
  end

  // timer counts the start delay, then stall cycles of each read
  always_comb begin
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state)
      WAIT: begin
        tmr_load = tmr_exp;
        tmr_dec  = !tmr_exp;
      end
      RD_ID: begin
        tmr_dec = avm.avm_read && avm.avm_waitrequest && !tmr_exp;
      end
      RD_TS: begin
        tmr_load = !avm.avm_read;
        tmr_dec  = avm.avm_read && avm.avm_waitrequest && !tmr_exp;
      end
      CHECK: begin
        tmr_load = 1'b1;
      end
      DONE: begin
        tmr_load = start;
        tmr_clr  = !start;
      end
      default: ;
    endcase
  end

  // sequencer with registered bus and status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= WAIT;
      avm.avm_read    <= 1'b0;
      avm.avm_address <= ADDR_ID;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_code       <= FC_NONE;
      id_value        <= '0;
      ts_value        <= '0;
      retry_cnt       <= '0;
      tmo             <= 1'b0;
`ifdef SYSID_CHK_IRQ_EN
      irq             <= 1'b0;
`endif
    end else begin
`ifdef SYSID_CHK_IRQ_EN
      if (irq_ack) irq <= 1'b0;
`endif
      unique case (state)
        WAIT: begin
          busy <= 1'b1;
          if (tmr_exp) begin
            state           <= RD_ID;
            avm.avm_read    <= 1'b1;
            avm.avm_address <= ADDR_ID;
          end
        end
        RD_ID: begin
          if (!avm.avm_waitrequest) begin
            id_value        <= avm.avm_readdata;
            avm.avm_read    <= 1'b0;
            avm.avm_address <= ADDR_TS;
            state           <= RD_TS;
          end else if (tmr_exp) begin
            avm.avm_read <= 1'b0;
            tmo          <= 1'b1;
            state        <= CHECK;
          end
        end
        RD_TS: begin
          if (!avm.avm_read) begin
            avm.avm_read <= 1'b1;
          end else if (!avm.avm_waitrequest) begin
            ts_value     <= avm.avm_readdata;
            avm.avm_read <= 1'b0;
            state        <= CHECK;
          end else if (tmr_exp) begin
            avm.avm_read <= 1'b0;
            tmo          <= 1'b1;
            state        <= CHECK;
          end
        end
        CHECK: begin
          tmo <= 1'b0;
          if (code == FC_NONE) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b1;
            fail_code <= FC_NONE;
          end else if (int'(retry_cnt) < MAX_RETRY) begin
            retry_cnt       <= retry_cnt + 2'd1;
            state           <= RD_ID;
            avm.avm_read    <= 1'b1;
            avm.avm_address <= ADDR_ID;
          end else begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            fail_code <= code;
`ifdef SYSID_CHK_IRQ_EN
            irq       <= 1'b1;
`endif
          end
        end
        DONE: begin
          if (start) begin
            retry_cnt       <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_code       <= FC_NONE;
            busy            <= 1'b1;
            state           <= RD_ID;
            avm.avm_read    <= 1'b1;
            avm.avm_address <= ADDR_ID;
`ifdef SYSID_CHK_IRQ_EN
            irq             <= 1'b0;
`endif
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Self-checking bench for sysid_boot_checker
// Vector table of slave behaviours plus start/reset sequences
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1380386782;
  localparam int          TMO    = 255;

  typedef struct {
    int          stall;
    bit          all;
    int          id_bad;
    int          ts_bad;
    bit          pass;
    logic [1:0]  fc;
    logic [1:0]  rty;
    int          cyc;
    logic [31:0] idv;
    logic [31:0] tsv;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic [1:0]  retry_cnt;
`ifdef SYSID_CHK_IRQ_EN
  logic        irq;
  logic        irq_ack;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  int stall_cfg = 0;
  bit stall_all = 1'b0;
  int id_bad = 0;
  int ts_bad = 0;
  int id_done = 0;
  int ts_done = 0;
  int id_base = 0;
  int ts_base = 0;
  int stall_ctr = 0;

  logic p_rd;
  logic p_wr;
  logic p_addr;
  int   run;

  vec_t tbl [9];

  always #5 clock = ~clock;

  sysid_boot_checker_if avm ();

  sysid_boot_checker #(
    .EXP_ID         (EXP_ID),
    .EXP_TIMESTAMP  (EXP_TS),
    .START_DELAY    (16),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRY      (3)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .avm       (avm),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_code (fail_code),
    .id_value  (id_value),
    .ts_value  (ts_value),
    .retry_cnt (retry_cnt)
`ifdef SYSID_CHK_IRQ_EN
    ,
    .irq       (irq),
    .irq_ack   (irq_ack)
`endif
  );

  // slave stall counter and completed-read tallies
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_ctr <= 0;
    end else if (!avm.avm_read) begin
      stall_ctr <= 0;
    end else if (avm.avm_waitrequest) begin
      stall_ctr <= stall_ctr + 1;
    end else begin
      stall_ctr <= 0;
      if (avm.avm_address) ts_done <= ts_done + 1;
      else id_done <= id_done + 1;
    end
  end

  // zero-latency slave response
  always_comb begin
    avm.avm_waitrequest = 1'b0;
    avm.avm_readdata    = '0;
    if (avm.avm_read)
      avm.avm_waitrequest = stall_all || (stall_ctr < stall_cfg);
    if (!avm.avm_address)
      avm.avm_readdata = (id_done - id_base < id_bad) ? 32'h1 : EXP_ID;
    else
      avm.avm_readdata = (ts_done - ts_base < ts_bad) ? 32'h0 : EXP_TS;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd"},   32'(avm.avm_read), 32'd0);
    chk({tag, "_addr"}, 32'(avm.avm_address), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_fc"},   32'(fail_code), 32'd0);
    chk({tag, "_id"},   id_value, 32'd0);
    chk({tag, "_ts"},   ts_value, 32'd0);
    chk({tag, "_rty"},  32'(retry_cnt), 32'd0);
`ifdef SYSID_CHK_IRQ_EN
    chk({tag, "_irq"},  32'(irq), 32'd0);
`endif
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic cfg(input int s, input bit a, input int ib, input int tb);
    stall_cfg = s;
    stall_all = a;
    id_bad    = ib;
    ts_bad    = tb;
    id_base   = id_done;
    ts_base   = ts_done;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clock);
    reset_n = 1'b0;
    cfg(v.stall, v.all, v.id_bad, v.ts_bad);
    #1;
    chk_reset({t, "_rst"});
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk({t, "_busy1"}, 32'(busy), 32'd1);
    wait_done(n);
    n++;
    chk({t, "_cyc"},  32'(n), 32'(v.cyc));
    chk({t, "_pass"}, 32'(pass), 32'(v.pass));
    chk({t, "_fc"},   32'(fail_code), 32'(v.fc));
    chk({t, "_rty"},  32'(retry_cnt), 32'(v.rty));
    chk({t, "_id"},   id_value, v.idv);
    chk({t, "_ts"},   ts_value, v.tsv);
    chk({t, "_busy"}, 32'(busy), 32'd0);
`ifdef SYSID_CHK_IRQ_EN
    chk({t, "_irq"},  32'(irq), 32'(!v.pass));
`endif
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
`ifdef SYSID_CHK_IRQ_EN
    irq_ack = 1'b0;
`endif
    p_rd   = 1'b0;
    p_wr   = 1'b0;
    p_addr = 1'b0;
    run    = 0;

    tbl[0] = '{0,   1'b0, 0,  0,  1'b1, 2'd0, 2'd0, 21,   32'd0, EXP_TS};
    tbl[1] = '{0,   1'b0, 99, 0,  1'b0, 2'd1, 2'd3, 33,   32'd1, EXP_TS};
    tbl[2] = '{0,   1'b0, 0,  2,  1'b1, 2'd0, 2'd2, 29,   32'd0, EXP_TS};
    tbl[3] = '{0,   1'b0, 0,  99, 1'b0, 2'd2, 2'd3, 33,   32'd0, 32'd0};
    tbl[4] = '{0,   1'b0, 99, 99, 1'b0, 2'd1, 2'd3, 33,   32'd1, 32'd0};
    tbl[5] = '{10,  1'b0, 0,  0,  1'b1, 2'd0, 2'd0, 41,   32'd0, EXP_TS};
    tbl[6] = '{254, 1'b0, 0,  0,  1'b1, 2'd0, 2'd0, 529,  32'd0, EXP_TS};
    tbl[7] = '{255, 1'b0, 0,  0,  1'b0, 2'd3, 2'd3, 1041, 32'd0, 32'd0};
    tbl[8] = '{0,   1'b1, 0,  0,  1'b0, 2'd3, 2'd3, 1041, 32'd0, 32'd0};

    // bus monitor: hold while stalled, drop after 255 stalls, gap after a read
    fork
      forever begin
        @(posedge clock);
        #3;
        if (!reset_n) begin
          p_rd = 1'b0;
          p_wr = 1'b0;
          run  = 0;
        end else begin
          if (p_rd && p_wr) begin
            if (run < TMO) begin
              chk("bus_hold_rd", 32'(avm.avm_read), 32'd1);
              chk("bus_hold_addr", 32'(avm.avm_address), 32'(p_addr));
            end else begin
              chk("tmo_drop", 32'(avm.avm_read), 32'd0);
            end
          end else if (p_rd) begin
            chk("rd_gap", 32'(avm.avm_read), 32'd0);
          end
          run    = (avm.avm_read && avm.avm_waitrequest) ? run + 1 : 0;
          p_rd   = avm.avm_read;
          p_wr   = avm.avm_waitrequest;
          p_addr = avm.avm_address;
        end
      end
    join_none

    foreach (tbl[i]) run_vec(tbl[i], i);

    // start in DONE reruns with cleared status; start while busy is dropped
    run_vec(tbl[2], 20);
    cfg(10, 1'b0, 0, 0);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    chk("st_done",  32'(done), 32'd0);
    chk("st_busy",  32'(busy), 32'd1);
    chk("st_rty",   32'(retry_cnt), 32'd0);
    chk("st_pass",  32'(pass), 32'd0);
    chk("st_fc",    32'(fail_code), 32'd0);
    chk("st_rd",    32'(avm.avm_read), 32'd1);
    chk("st_addr",  32'(avm.avm_address), 32'd0);
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
      if (n == 15) begin
        chk("st_in_rdts", {30'd0, avm.avm_address, avm.avm_read}, 32'd3);
        @(negedge clock);
        start = 1'b1;
      end
      if (n == 16) begin
        @(negedge clock);
        start = 1'b0;
      end
    end
    chk("st2_cyc",  32'(n), 32'd24);
    chk("st2_pass", 32'(pass), 32'd1);
    chk("st2_rty",  32'(retry_cnt), 32'd0);
    chk("st2_fc",   32'(fail_code), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      chk("st2_hold_done", 32'(done), 32'd1);
      chk("st2_hold_busy", 32'(busy), 32'd0);
    end

    // reset pulse in the middle of the timestamp read
    @(negedge clock);
    reset_n = 1'b0;
    cfg(10, 1'b0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    while (n < 32) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("mr_in_rdts", {30'd0, avm.avm_address, avm.avm_read}, 32'd3);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset("mr");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    wait_done(n);
    chk("mr_cyc",  32'(n), 32'd41);
    chk("mr_pass", 32'(pass), 32'd1);
    chk("mr_rty",  32'(retry_cnt), 32'd0);
    chk("mr_ts",   ts_value, EXP_TS);

`ifdef SYSID_CHK_IRQ_EN
    // irq holds after a failed run until acknowledged
    run_vec(tbl[1], 30);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      chk("irq_hold", 32'(irq), 32'd1);
    end
    @(negedge clock);
    irq_ack = 1'b1;
    @(posedge clock);
    #1;
    chk("irq_ack", 32'(irq), 32'd0);
    @(negedge clock);
    irq_ack = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
